traffic_request_conditioner: RTL and testbench
==============================================

Name: traffic_request_conditioner

Overview:
- Input-side stage sitting directly upstream of the traffic-light sequencer.
- Synchronises and debounces two raw field inputs: the pedestrian push-button and the side-road vehicle sensor.
- Turns each into a latched request that stays high until the sequencer acknowledges it.
- Keeps a saturating count of side-road vehicle arrivals so the sequencer can judge demand.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive clocks a changed input must hold before acceptance (20 ms at 50 MHz); must be >= 2.
- CNT_W, 4, width of the side-road arrival counter.
- TIMEOUT_CYCLES, 3000000000, clocks an unacknowledged request may stay pending; used only with REQ_TIMEOUT_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ped_raw  in  1  raw pedestrian button, active-high, asynchronous to clk
- side_raw  in  1  raw side-road sensor, active-high, asynchronous to clk
- ack_ped  in  1  one-cycle pulse from the sequencer: pedestrian request serviced
- ack_side  in  1  one-cycle pulse from the sequencer: side-road request serviced
- req_ped  out  1  pending pedestrian request (level)
- req_side  out  1  pending side-road request (level)
- side_count  out  CNT_W  side-road arrivals since the last ack_side, saturating
- req_timeout  out  1  one-cycle pulse when a request expires (held 0 without REQ_TIMEOUT_EN)

Behaviour:
- Reset (asynchronous, active-high):
  - all synchroniser flops, debounced states, debounce counters, req_ped, req_side, side_count and req_timeout go to 0;
  - any debounce or request in progress is discarded.
- Per channel, identical logic:
  - Synchroniser: two-flop synchroniser, output s2.
  - Debounce counter cnt (width clog2(DEBOUNCE_CYCLES)):
    - clears on every edge where s2 == db;
    - increments on every edge where s2 != db;
    - on the edge where s2 != db and cnt == DEBOUNCE_CYCLES-1: db takes s2 and cnt clears.
  - Edge pulse: evt is a registered one-cycle pulse on the same edge that db goes 0->1. Falling db produces no event.
- Latency:
  - Raw input high before edge 1 and held: s2=1 after edge 2, db=1 and evt=1 after edge DEBOUNCE_CYCLES+2, req=1 after edge DEBOUNCE_CYCLES+3.
  - Raw highs lasting fewer than DEBOUNCE_CYCLES clocks are rejected with no event.
- Request latch:
  - evt sets req; ack clears req.
  - evt and ack on the same edge: req stays 1, so the new arrival wins.
  - Ack while req=0 is ignored.
  - A repeated evt while req=1 holds req=1.
- side_count:
  - +1 on each side evt, saturating at 2^CNT_W-1;
  - ack_side loads 0;
  - ack_side together with evt loads 1.
- Ped and side channels are fully independent; acks affect only their own channel.

Optional Feature:
- REQ_TIMEOUT_EN defined:
  - per-channel age counter (32-bit) clears when req rises or on any evt, and counts while req=1;
  - on reaching TIMEOUT_CYCLES-1, req clears and req_timeout pulses for 1 cycle;
  - ped and side timing out on the same edge give a single req_timeout pulse;
  - the side timeout also clears side_count;
  - ack on the expiry edge clears req with no req_timeout pulse.
- Not defined: no age counters; requests are held until acked; req_timeout is tied to 0.

Decomposition:
- Shared package traffic_pkg:
  - light encodings (RED 3'b100, YELLOW 3'b010, GREEN 3'b001);
  - sequencer state typedef;
  - default DEBOUNCE_CYCLES and TIMEOUT_CYCLES constants.
- Sub-module input_debouncer (synchroniser + debounce counter + rise pulse), instantiated twice; request latching, side_count and the timeout logic stay at top level.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=4, TIMEOUT_CYCLES=20):
- ped_raw 0->1 before edge 1, held -> req_ped=1 after edge 7 and not earlier; req_side stays 0.
- ped_raw high for 3 cycles, then bouncing 1/0 every cycle for 20 cycles -> req_ped never rises.
- 17 debounced side_raw presses with no ack -> side_count saturates at 15 and req_side=1; ack_side -> side_count=0 and req_side=0 the next cycle.
- ack_side on the same edge as a side evt -> req_side stays 1 and side_count=1.
- reset asserted mid-debounce (cnt=2) and mid-request -> all outputs 0 at once; after release, a fresh press needs the full 7-edge latency.
- With REQ_TIMEOUT_EN: req_ped pending with no ack -> req_ped clears after 20 cycles with a single req_timeout pulse; repeat with ack_ped on the expiry edge -> req_ped clears and req_timeout stays 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-light controller: light encodings,
// sequencer state type and default timing constants.
package traffic_pkg;

    // One-hot lamp encodings driven by the sequencer.
    localparam logic [2:0] LIGHT_RED    = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_GREEN  = 3'b001;

    // Sequencer phases; lives here so the sequencer and its neighbours agree.
    typedef enum logic [1:0] {
        SEQ_MAIN_GREEN  = 2'd0,
        SEQ_MAIN_YELLOW = 2'd1,
        SEQ_SIDE_GREEN  = 2'd2,
        SEQ_SIDE_YELLOW = 2'd3
    } seq_state_e;

    // 20 ms at 50 MHz.
    localparam int unsigned DEF_DEBOUNCE_CYCLES = 1000000;
    // 60 s at 50 MHz; does not fit a signed int, hence the 32-bit vector.
    localparam logic [31:0] DEF_TIMEOUT_CYCLES  = 32'd3000000000;

endpackage

// File: rtl/input_debouncer.sv
// Two-flop synchroniser, debounce counter and rising-edge event pulse for
// one raw field input. The debounced level is accepted only after it has
// differed from the current state for DEBOUNCE_CYCLES consecutive clocks.
module input_debouncer
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_i,
    output logic evt_o
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1_q, s2_q;
    logic            db_q, db_d;
    logic            evt_q, evt_d;
    logic [DB_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous raw input into the clk domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= raw_i;
            s2_q <= s1_q;
        end
    end

    // Count how long s2 has disagreed with the debounced state; accept on the last count.
    always_comb begin
        db_d  = db_q;
        cnt_d = '0;
        evt_d = 1'b0;
        if (s2_q != db_q) begin
            if (cnt_q == CNT_MAX) begin
                db_d  = s2_q;
                evt_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Debounce state registers; evt is a one-cycle pulse on the accepted 0->1 edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            db_q  <= 1'b0;
            cnt_q <= '0;
            evt_q <= 1'b0;
        end else begin
            db_q  <= db_d;
            cnt_q <= cnt_d;
            evt_q <= evt_d;
        end
    end

    assign evt_o = evt_q;

endmodule

// File: rtl/traffic_request_conditioner.sv
// Conditions the pedestrian button and side-road sensor for the sequencer:
// debounced arrivals become latched requests held until acknowledged, and
// side-road arrivals are counted (saturating) since the last side ack.
// Optional build macro REQ_TIMEOUT_EN: pending requests expire after
// TIMEOUT_CYCLES clocks and report a one-cycle req_timeout pulse.
module traffic_request_conditioner
    import traffic_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int          CNT_W           = 4,
    parameter logic [31:0] TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ped_raw,
    input  logic             side_raw,
    input  logic             ack_ped,
    input  logic             ack_side,
    output logic             req_ped,
    output logic             req_side,
    output logic [CNT_W-1:0] side_count,
    output logic             req_timeout
);

    logic             ped_evt, side_evt;
    logic             req_ped_q, req_ped_d;
    logic             req_side_q, req_side_d;
    logic [CNT_W-1:0] side_count_q, side_count_d;
    logic             timeout_q, timeout_d;
    logic             ped_exp, side_exp;

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ped_db (
        .clk   (clk),
        .reset (reset),
        .raw_i (ped_raw),
        .evt_o (ped_evt)
    );

    input_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_side_db (
        .clk   (clk),
        .reset (reset),
        .raw_i (side_raw),
        .evt_o (side_evt)
    );

`ifdef REQ_TIMEOUT_EN
    logic [31:0] ped_age_q, ped_age_d;
    logic [31:0] side_age_q, side_age_d;

    // A fresh arrival on the expiry edge restarts the request rather than expiring it.
    assign ped_exp  = req_ped_q  && (ped_age_q  == TIMEOUT_CYCLES - 32'd1) && !ped_evt;
    assign side_exp = req_side_q && (side_age_q == TIMEOUT_CYCLES - 32'd1) && !side_evt;

    // Age counters restart on any arrival or request rise and run while a request is pending.
    always_comb begin
        ped_age_d  = '0;
        side_age_d = '0;
        if (!(ped_evt || (req_ped_d && !req_ped_q)) && req_ped_q)
            ped_age_d = ped_age_q + 32'd1;
        if (!(side_evt || (req_side_d && !req_side_q)) && req_side_q)
            side_age_d = side_age_q + 32'd1;
    end

    // Age counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ped_age_q  <= '0;
            side_age_q <= '0;
        end else begin
            ped_age_q  <= ped_age_d;
            side_age_q <= side_age_d;
        end
    end
`else
    // Without the timeout option requests never expire.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign ped_exp  = 1'b0;
    assign side_exp = 1'b0;
`endif

    // Request latches, arrival counter and timeout pulse; a new arrival beats a same-edge ack.
    always_comb begin
        req_ped_d = req_ped_q;
        if (ack_ped || ped_exp) req_ped_d = 1'b0;
        if (ped_evt)            req_ped_d = 1'b1;

        req_side_d = req_side_q;
        if (ack_side || side_exp) req_side_d = 1'b0;
        if (side_evt)             req_side_d = 1'b1;

        side_count_d = side_count_q;
        if (ack_side) begin
            side_count_d = side_evt ? CNT_W'(1) : '0;
        end else if (side_exp) begin
            side_count_d = '0;
        end else if (side_evt && (side_count_q != {CNT_W{1'b1}})) begin
            side_count_d = side_count_q + 1'b1;
        end

        // An ack on the expiry edge counts as service, not as a timeout.
        timeout_d = (ped_exp && !ack_ped) || (side_exp && !ack_side);
    end

    // Output state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_ped_q    <= 1'b0;
            req_side_q   <= 1'b0;
            side_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            req_ped_q    <= req_ped_d;
            req_side_q   <= req_side_d;
            side_count_q <= side_count_d;
            timeout_q    <= timeout_d;
        end
    end

    assign req_ped     = req_ped_q;
    assign req_side    = req_side_q;
    assign side_count  = side_count_q;
    assign req_timeout = timeout_q;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Bench for traffic_request_conditioner with DEBOUNCE_CYCLES=4, CNT_W=4,
// TIMEOUT_CYCLES=20. Inputs change 1 time unit after a rising edge, so
// "after edge N" means N ticks after the stimulus was applied.
module tb_traffic_request_conditioner;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ped_raw, side_raw, ack_ped, ack_side;
    logic             req_ped, req_side, req_timeout;
    logic [CNT_W-1:0] side_count;

    int n_checks = 0;
    int n_errors = 0;
    int timeout_pulses = 0;
    logic [CNT_W-1:0] exp_q[$];

    traffic_request_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (32'd20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ped_raw    (ped_raw),
        .side_raw   (side_raw),
        .ack_ped    (ack_ped),
        .ack_side   (ack_side),
        .req_ped    (req_ped),
        .req_side   (req_side),
        .side_count (side_count),
        .req_timeout(req_timeout)
    );

    // Clock and timeout-pulse monitor (sampled on the falling edge).
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (req_timeout === 1'b1) timeout_pulses++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // One clean side-road arrival: held long enough to be accepted, then released.
    task automatic press_side();
        side_raw = 1'b1;
        ticks(6);
        side_raw = 1'b0;
        ticks(6);
    endtask

    // Pop the next expected side_count and compare against the DUT.
    task automatic sb_check_side(input string tag);
        logic [CNT_W-1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, 32'(side_count), 32'(e));
        end
    endtask

    initial begin
        logic seen;
        int   p0;

        reset = 1'b1; ped_raw = 1'b0; side_raw = 1'b0; ack_ped = 1'b0; ack_side = 1'b0;
        ticks(2);
        check("reset_req_ped", 32'(req_ped), 32'd0);
        check("reset_req_side", 32'(req_side), 32'd0);
        check("reset_side_count", 32'(side_count), 32'd0);
        check("reset_timeout", 32'(req_timeout), 32'd0);
        reset = 1'b0;

        // Clean pedestrian press: request appears after edge 7, not before.
        ped_raw = 1'b1;
        ticks(6);
        check("ped_not_early", 32'(req_ped), 32'd0);
        tick();
        check("ped_latency", 32'(req_ped), 32'd1);
        check("side_untouched", 32'(req_side), 32'd0);
        ped_raw = 1'b0;
        ack_ped = 1'b1;
        tick();
        ack_ped = 1'b0;
        check("ped_acked", 32'(req_ped), 32'd0);
        ticks(8);
        check("ped_no_rerequest", 32'(req_ped), 32'd0);

        // Short press then bouncing: never accepted.
        seen = 1'b0;
        ped_raw = 1'b1;
        ticks(3);
        for (int i = 0; i < 20; i++) begin
            ped_raw = i[0];
            tick();
            seen |= req_ped;
        end
        ped_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            seen |= req_ped;
        end
        check("bounce_rejected", 32'(seen), 32'd0);

        // 17 side arrivals without ack: count saturates at 15.
        for (int k = 1; k <= 17; k++) begin
            exp_q.push_back((k > 15) ? CNT_W'(15) : CNT_W'(k));
            press_side();
            sb_check_side("side_count_inc");
        end
        check("side_req_pending", 32'(req_side), 32'd1);
        check("ped_independent", 32'(req_ped), 32'd0);
        ack_side = 1'b1;
        tick();
        ack_side = 1'b0;
        check("ack_side_count", 32'(side_count), 32'd0);
        check("ack_side_req", 32'(req_side), 32'd0);

        // Ack on the same edge as a new arrival: arrival wins, count reloads to 1.
        exp_q.push_back(CNT_W'(1));
        press_side();
        sb_check_side("side_count_first");
        check("side_req_first", 32'(req_side), 32'd1);
        side_raw = 1'b1;
        ticks(6);
        ack_side = 1'b1;
        tick();
        ack_side = 1'b0;
        exp_q.push_back(CNT_W'(1));
        sb_check_side("ack_evt_count");
        check("ack_evt_req", 32'(req_side), 32'd1);

        // Reset mid-debounce (ped) and mid-request (side): outputs clear immediately.
        ped_raw = 1'b1;
        ticks(4);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_req_ped", 32'(req_ped), 32'd0);
        check("midreset_req_side", 32'(req_side), 32'd0);
        check("midreset_side_count", 32'(side_count), 32'd0);
        check("midreset_timeout", 32'(req_timeout), 32'd0);
        ped_raw = 1'b0;
        side_raw = 1'b0;
        ticks(2);
        reset = 1'b0;
        ped_raw = 1'b1;
        ticks(6);
        check("postreset_not_early", 32'(req_ped), 32'd0);
        tick();
        check("postreset_latency", 32'(req_ped), 32'd1);

`ifdef REQ_TIMEOUT_EN
        // Unacknowledged request expires after 20 cycles with one pulse.
        p0 = timeout_pulses;
        ticks(19);
        check("to_still_pending", 32'(req_ped), 32'd1);
        tick();
        check("to_expired", 32'(req_ped), 32'd0);
        check("to_pulse", 32'(req_timeout), 32'd1);
        tick();
        check("to_pulse_end", 32'(req_timeout), 32'd0);
        check("to_pulse_count", 32'(timeout_pulses - p0), 32'd1);

        // Ack on the expiry edge: cleared as serviced, no timeout pulse.
        ped_raw = 1'b0;
        ticks(8);
        ped_raw = 1'b1;
        ticks(7);
        check("to2_pending", 32'(req_ped), 32'd1);
        p0 = timeout_pulses;
        ticks(19);
        ack_ped = 1'b1;
        tick();
        ack_ped = 1'b0;
        check("to2_acked", 32'(req_ped), 32'd0);
        check("to2_no_pulse", 32'(req_timeout), 32'd0);
        tick();
        check("to2_pulse_count", 32'(timeout_pulses - p0), 32'd0);
`else
        // Without the timeout option a request is held indefinitely.
        p0 = timeout_pulses;
        ticks(40);
        check("held_no_timeout", 32'(req_ped), 32'd1);
        check("no_timeout_pulses", 32'(timeout_pulses - p0), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
